// File: rtl/intirvx_writeback.sv
// Writeback stage of the intirvx core: round-robin accept from ALU/LSU, register-file write,
// jump redirect with a one-cycle flush, and retired-instruction counting.
module intirvx_writeback #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      alu_result,
  input  logic [4:0]           alu_rd,
  input  logic                 alu_jump,
  input  logic [XLEN-1:0]      alu_jump_addr,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [XLEN-1:0]      lsu_result,
  input  logic [4:0]           lsu_rd,
  input  logic                 lsu_valid,
  output logic                 lsu_ready,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 pc_redirect,
  output logic [XLEN-1:0]      pc_redirect_addr,
  output logic                 flush,
  output logic [CNT_WIDTH-1:0] instret
);

  logic            last_grant_alu;
  logic            grant_alu;
  logic            alu_fire;
  logic            lsu_fire;
  logic            stage_valid;
  logic            stage_jump;
  logic [4:0]      stage_rd;
  logic [XLEN-1:0] stage_data;
  logic [XLEN-1:0] stage_jump_addr;

  // On a tie, the channel that did not win the last transfer gets the grant.
  always_comb begin
    grant_alu = 1'b0;
    if (alu_valid && lsu_valid) begin
      grant_alu = !last_grant_alu;
    end else begin
      grant_alu = alu_valid;
    end
  end

  assign alu_ready = !flush && alu_valid && grant_alu;
  assign lsu_ready = !flush && lsu_valid && !grant_alu;
  assign alu_fire  = alu_valid && alu_ready;
  assign lsu_fire  = lsu_valid && lsu_ready;

  // The jump target is stored already halfword-aligned, so the redirect needs no extra logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid     <= 1'b0;
      stage_jump      <= 1'b0;
      stage_rd        <= 5'd0;
      stage_data      <= '0;
      stage_jump_addr <= '0;
      last_grant_alu  <= 1'b0;
      instret         <= '0;
    end else begin
      stage_valid <= alu_fire || lsu_fire;
      if (alu_fire) begin
        stage_rd        <= alu_rd;
        stage_data      <= alu_result;
        stage_jump      <= alu_jump;
        stage_jump_addr <= {alu_jump_addr[XLEN-1:1], 1'b0};
      end else if (lsu_fire) begin
        stage_rd        <= lsu_rd;
        stage_data      <= lsu_result;
        stage_jump      <= 1'b0;
        stage_jump_addr <= '0;
      end
      if (alu_fire || lsu_fire) begin
        last_grant_alu <= alu_fire;
        instret        <= instret + CNT_WIDTH'(1);
      end
    end
  end

  assign rf_we            = stage_valid && (stage_rd != 5'd0);
  assign rf_waddr         = stage_rd;
  assign rf_wdata         = stage_data;
  assign flush            = stage_valid && stage_jump;
  assign pc_redirect      = flush;
  assign pc_redirect_addr = stage_jump_addr;

endmodule

// File: tb/tb_intirvx_writeback.sv
// Scoreboard bench for intirvx_writeback: directed transfers push expected retirements,
// a monitor pops and compares them whenever the stage shows a retirement.
module tb_intirvx_writeback;

  localparam int XLEN = 32;
  localparam int CW   = 4;

  typedef struct {
    logic [4:0]    rd;
    logic [31:0]   data;
    logic          jump;
    logic [31:0]   addr;
    logic [CW-1:0] cnt;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [31:0]     alu_result;
  logic [4:0]      alu_rd;
  logic            alu_jump;
  logic [31:0]     alu_jump_addr;
  logic            alu_valid;
  logic            alu_ready;
  logic [31:0]     lsu_result;
  logic [4:0]      lsu_rd;
  logic            lsu_valid;
  logic            lsu_ready;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic            pc_redirect;
  logic [31:0]     pc_redirect_addr;
  logic            flush;
  logic [CW-1:0]   instret;

  int              errors = 0;
  int              checks = 0;
  exp_t            sb[$];
  logic [CW-1:0]   exp_cnt = '0;
  logic [CW-1:0]   prev_instret = '0;

  intirvx_writeback #(.XLEN(XLEN), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .alu_result(alu_result), .alu_rd(alu_rd), .alu_jump(alu_jump),
    .alu_jump_addr(alu_jump_addr), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .lsu_result(lsu_result), .lsu_rd(lsu_rd), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_redirect(pc_redirect), .pc_redirect_addr(pc_redirect_addr),
    .flush(flush), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One input cycle; hand-computed readies decide which result gets queued as retired.
  task automatic applyStimulus(
    input logic av, input logic [4:0] ard, input logic [31:0] ares,
    input logic aj, input logic [31:0] aaddr,
    input logic lv, input logic [4:0] lrd, input logic [31:0] lres,
    input logic exp_ar, input logic exp_lr);
    exp_t e;
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_result = ares; alu_jump = aj; alu_jump_addr = aaddr;
    lsu_valid = lv; lsu_rd = lrd; lsu_result = lres;
    #1;
    checkOutput("alu_ready", {63'd0, alu_ready}, {63'd0, exp_ar});
    checkOutput("lsu_ready", {63'd0, lsu_ready}, {63'd0, exp_lr});
    if (exp_ar) begin
      exp_cnt = exp_cnt + 1'b1;
      e.rd = ard; e.data = ares; e.jump = aj; e.addr = {aaddr[31:1], 1'b0}; e.cnt = exp_cnt;
      sb.push_back(e);
    end else if (exp_lr) begin
      exp_cnt = exp_cnt + 1'b1;
      e.rd = lrd; e.data = lres; e.jump = 1'b0; e.addr = 32'd0; e.cnt = exp_cnt;
      sb.push_back(e);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0; alu_jump = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_rf_we"}, {63'd0, rf_we}, 64'd0);
    checkOutput({tag, "_rf_waddr"}, {59'd0, rf_waddr}, 64'd0);
    checkOutput({tag, "_rf_wdata"}, {32'd0, rf_wdata}, 64'd0);
    checkOutput({tag, "_pc_redirect"}, {63'd0, pc_redirect}, 64'd0);
    checkOutput({tag, "_pc_redirect_addr"}, {32'd0, pc_redirect_addr}, 64'd0);
    checkOutput({tag, "_flush"}, {63'd0, flush}, 64'd0);
    checkOutput({tag, "_instret"}, {60'd0, instret}, 64'd0);
    checkOutput({tag, "_alu_ready"}, {63'd0, alu_ready}, 64'd0);
    checkOutput({tag, "_lsu_ready"}, {63'd0, lsu_ready}, 64'd0);
  endtask

  // Monitor: any retirement visible on the outputs must match the oldest queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      prev_instret = instret;
    end else if (rf_we || pc_redirect || flush || instret != prev_instret) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_retire actual=rf_we:%0b addr:%0h instret:%0h expected=none",
                 rf_we, rf_waddr, instret);
      end else begin
        e = sb.pop_front();
        checkOutput("rf_we", {63'd0, rf_we}, {63'd0, (e.rd != 5'd0)});
        checkOutput("rf_waddr", {59'd0, rf_waddr}, {59'd0, e.rd});
        checkOutput("rf_wdata", {32'd0, rf_wdata}, {32'd0, e.data});
        checkOutput("pc_redirect", {63'd0, pc_redirect}, {63'd0, e.jump});
        checkOutput("flush", {63'd0, flush}, {63'd0, e.jump});
        if (e.jump) checkOutput("pc_redirect_addr", {32'd0, pc_redirect_addr}, {32'd0, e.addr});
        checkOutput("instret", {60'd0, instret}, {60'd0, e.cnt});
      end
      prev_instret = instret;
    end
  end

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_result = '0; alu_jump = 1'b0; alu_jump_addr = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_result = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkIdleOutputs("reset");
    rst = 1'b0;

    // ALU only, then an LSU result to x0 that retires without writing
    applyStimulus(1'b1, 5'd5, 32'h0000_1234, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b1);

    // Contention: grants alternate ALU, LSU, ALU, LSU, then the pending ALU item drains
    applyStimulus(1'b1, 5'd10, 32'hA000_0000, 1'b0, 32'd0, 1'b1, 5'd11, 32'hB000_0000, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd12, 32'hA000_0001, 1'b0, 32'd0, 1'b1, 5'd11, 32'hB000_0000, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd12, 32'hA000_0001, 1'b0, 32'd0, 1'b1, 5'd13, 32'hB000_0001, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd14, 32'hA000_0002, 1'b0, 32'd0, 1'b1, 5'd13, 32'hB000_0001, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd14, 32'hA000_0002, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);

    // Jump: flush cycle refuses both channels, then the tie goes to the LSU
    applyStimulus(1'b1, 5'd1, 32'h0000_0104, 1'b1, 32'h8000_0103, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd2, 32'h0000_0222, 1'b0, 32'd0, 1'b1, 5'd3, 32'h0000_0333, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd2, 32'h0000_0222, 1'b0, 32'd0, 1'b1, 5'd3, 32'h0000_0333, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd2, 32'h0000_0222, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // Counter wrap: 17 back-to-back retirements from zero
    doReset();
    for (int i = 0; i < 17; i++) begin
      if (i % 2 == 0)
        applyStimulus(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      else
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'(i), 32'h200 + 32'(i), 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // Reset mid-stream: a result offered while reset is sampled must vanish
    @(negedge clk);
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_result = 32'h77; alu_jump = 1'b1; alu_jump_addr = 32'h4000;
    @(negedge clk);
    rst = 1'b0;
    alu_valid = 1'b0; alu_jump = 1'b0;
    exp_cnt = '0;
    #1;
    checkIdleOutputs("midreset");
    applyStimulus(1'b1, 5'd8, 32'h88, 1'b0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
